// File: rtl/bist_pkg.sv
// Shared definitions for the subcircuit BIST controller: FSM encoding,
// polynomial taps and the LFSR/MISR step function.
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRST,
        S_APPLY,
        S_FLUSH,
        S_CMP,
        S_DONE
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form, taps at bits 15,13,12,10
    localparam logic [15:0] POLY_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & POLY_TAPS)};
    endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit shift register used both as pattern generator (COMPACT=0) and as a
// single-input signature compactor (COMPACT=1, sin folded into bit 0).
module bist_lfsr16
    import bist_pkg::*;
#(
    parameter bit COMPACT = 1'b0,
    parameter int OUT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [15:0]      load_val,
    input  logic             en,
    input  logic             sin,
    output logic [OUT_W-1:0] q
);

    logic [15:0] r;
    logic        fold;

    assign fold = COMPACT ? sin : 1'b0;

    // clear wins over load so a new run can never inherit a stale signature
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r <= '0;
        else if (clr)  r <= '0;
        else if (load) r <= load_val;
        else if (en)   r <= lfsr_step(r) ^ {15'b0, fold};
    end

    assign q = r[OUT_W-1:0];

endmodule

// File: rtl/subckt_bist_ctrl.sv
// BIST sequencer for one registered subcircuit: reset target, drive LFSR
// patterns, compact the latency-aligned response into a MISR, compare golden.
module subckt_bist_ctrl
    import bist_pkg::*;
#(
    parameter int NIN     = 5,
    parameter int LAT     = 2,
    parameter int RST_CYC = 2,
    parameter int CNT_W   = 16
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic             start,
    input  logic [15:0]      seed,
    input  logic [CNT_W-1:0] pat_cnt,
    input  logic [15:0]      golden,
    input  logic             dut_out,
    output logic [NIN-1:0]   dut_in,
    output logic             dut_rst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      signature
);

    state_t           state, next;
    logic [CNT_W-1:0] pat_r, pcnt;
    logic [15:0]      golden_r, rcnt;
    logic [3:0]       fcnt;
    logic [LAT-1:0]   vld_pipe, vld_next;
    logic [NIN-1:0]   lfsr_low;
    logic             accept, lfsr_en, vld_in, pass_r;

    always_ff @(posedge I1470_clk or posedge I1477_rst) begin
        if (I1477_rst) state <= S_IDLE;
        else           state <= next;
    end

    always_comb begin
        next    = state;
        accept  = 1'b0;
        lfsr_en = 1'b0;
        vld_in  = 1'b0;
        dut_in  = '0;
        case (state)
            S_IDLE, S_DONE: if (start) begin
                accept = 1'b1;
                next   = S_TRST;
            end
            S_TRST:  if (rcnt == 16'd0) next = (pat_r != '0) ? S_APPLY : S_FLUSH;
            S_APPLY: begin
                dut_in  = lfsr_low;
                lfsr_en = 1'b1;
                vld_in  = 1'b1;
                if (pcnt == pat_r - CNT_W'(1)) next = S_FLUSH;
            end
            S_FLUSH: if (fcnt == 4'd0) next = S_CMP;
            S_CMP:   next = S_DONE;
            default: next = S_IDLE;
        endcase
        dut_rst = I1477_rst | (state == S_TRST);
        busy    = (state == S_TRST) || (state == S_APPLY) || (state == S_FLUSH) || (state == S_CMP);
        done    = (state == S_DONE);
        pass    = done & pass_r;
    end

    generate
        if (LAT == 1) begin : g_vld1
            assign vld_next = vld_in;
        end else begin : g_vldn
            assign vld_next = {vld_pipe[LAT-2:0], vld_in};
        end
    endgenerate

    always_ff @(posedge I1470_clk or posedge I1477_rst) begin
        if (I1477_rst) begin
            pat_r    <= '0;
            golden_r <= '0;
            pcnt     <= '0;
            rcnt     <= '0;
            fcnt     <= '0;
            vld_pipe <= '0;
            pass_r   <= 1'b0;
        end else begin
            vld_pipe <= accept ? '0 : vld_next;
            if (accept) begin
                pat_r    <= pat_cnt;
                golden_r <= golden;
                pcnt     <= '0;
                rcnt     <= 16'(RST_CYC - 1);
                pass_r   <= 1'b0;
            end
            if (state == S_TRST && rcnt != 16'd0) rcnt <= rcnt - 16'd1;
            if (state == S_APPLY) pcnt <= pcnt + CNT_W'(1);
            // fcnt sits preloaded outside FLUSH so both TRST and APPLY can enter it
            if (state != S_FLUSH)      fcnt <= 4'(LAT - 1);
            else if (fcnt != 4'd0)     fcnt <= fcnt - 4'd1;
            if (state == S_CMP) pass_r <= (signature == golden_r);
        end
    end

    bist_lfsr16 #(.COMPACT(1'b0), .OUT_W(NIN)) u_lfsr (
        .clk      (I1470_clk),
        .rst      (I1477_rst),
        .clr      (1'b0),
        .load     (accept),
        .load_val ((seed == 16'h0) ? DEFAULT_SEED : seed),
        .en       (lfsr_en),
        .sin      (1'b0),
        .q        (lfsr_low)
    );

    bist_lfsr16 #(.COMPACT(1'b1), .OUT_W(16)) u_misr (
        .clk      (I1470_clk),
        .rst      (I1477_rst),
        .clr      (accept),
        .load     (1'b0),
        .load_val (16'h0),
        .en       (vld_pipe[LAT-1]),
        .sin      (dut_out),
        .q        (signature)
    );

endmodule

// File: tb/tb_subckt_bist_ctrl.sv
// Directed bench for subckt_bist_ctrl: vector table of complete runs plus
// hand sequences for zero seed, ignored start and mid-run reset.
module tb_subckt_bist_ctrl;
    localparam int NIN = 5, LAT = 2, RST_CYC = 2, CNT_W = 16;

    logic             clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0]      seed = '0, golden = '0;
    logic [CNT_W-1:0] pat_cnt = '0;
    logic             dut_out;
    logic [NIN-1:0]   dut_in;
    logic             dut_rst, busy, done, pass;
    logic [15:0]      signature;

    logic [1:0]       mode = 2'd0;  // 0: tied low, 1: tied high, 2: dut_in[0] delayed 2 cycles
    logic             d1, d2;
    int               checks = 0, errors = 0;

    logic [NIN-1:0]   ap [4];
    int               napp, cyc;
    bit               din_nz, busy_low;

    subckt_bist_ctrl #(.NIN(NIN), .LAT(LAT), .RST_CYC(RST_CYC), .CNT_W(CNT_W)) dut (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .start     (start),
        .seed      (seed),
        .pat_cnt   (pat_cnt),
        .golden    (golden),
        .dut_out   (dut_out),
        .dut_in    (dut_in),
        .dut_rst   (dut_rst),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge dut_rst) begin
        if (dut_rst) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d1 <= dut_in[0];
            d2 <= d1;
        end
    end

    assign dut_out = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? d2 : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete run; poke pulses a foreign start during the first APPLY cycle.
    task automatic run(input logic [15:0] s, input logic [CNT_W-1:0] p,
                       input logic [15:0] g, input bit poke);
        @(negedge clk);
        seed = s; pat_cnt = p; golden = g; start = 1'b1;
        @(negedge clk);
        start = 1'b0; seed = 16'h1234; pat_cnt = 16'd1; golden = 16'hFFFF;
        napp = 0; cyc = 0; din_nz = 0; busy_low = 0;
        chk("trst_dut_rst", dut_rst, 1'b1);
        while (!done && cyc < 500) begin
            start = 1'b0;
            if (dut_in != '0) din_nz = 1;
            if (!busy) busy_low = 1;
            if (busy && !dut_rst) begin
                if (napp < 4) ap[napp] = dut_in;
                napp++;
                if (poke && napp == 1) begin
                    start = 1'b1;
                    seed  = 16'h5555;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_reached", done, 1'b1);
    endtask

    typedef struct {
        logic [15:0]      seed;
        logic [CNT_W-1:0] pat;
        logic [15:0]      golden;
        logic [1:0]       mode;
        logic [15:0]      sig;
        logic             pass;
    } vec_t;

    vec_t tv [8];

    initial begin
        tv[0] = '{16'h0000, 16'd0,  16'h0000, 2'd0, 16'h0000, 1'b1};
        tv[1] = '{16'h0001, 16'd2,  16'h0003, 2'd1, 16'h0003, 1'b1};
        tv[2] = '{16'h0001, 16'd2,  16'h0002, 2'd1, 16'h0003, 1'b0};
        tv[3] = '{16'h0001, 16'd1,  16'h0001, 2'd2, 16'h0001, 1'b1};
        tv[4] = '{16'h0001, 16'd3,  16'h0004, 2'd2, 16'h0004, 1'b1};
        tv[5] = '{16'h0000, 16'd5,  16'h0000, 2'd0, 16'h0000, 1'b1};
        tv[6] = '{16'h0001, 16'd12, 16'h0FFE, 2'd1, 16'h0FFE, 1'b1};
        tv[7] = '{16'h0001, 16'd3,  16'h0000, 2'd1, 16'h0007, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_dut_rst", dut_rst, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_sig", signature, 16'h0);
        chk("rst_dut_in", dut_in, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_dut_rst", dut_rst, 1'b0);

        for (int i = 0; i < 8; i++) begin
            mode = tv[i].mode;
            run(tv[i].seed, tv[i].pat, tv[i].golden, 1'b0);
            chk($sformatf("v%0d_sig", i), signature, tv[i].sig);
            chk($sformatf("v%0d_pass", i), pass, tv[i].pass);
            chk($sformatf("v%0d_busy_held", i), busy_low, 1'b0);
            chk($sformatf("v%0d_busy_done", i), busy, 1'b0);
            if (i == 0) begin
                chk("cnt0_latency", cyc, 5);
                chk("cnt0_din_quiet", din_nz, 1'b0);
            end
            if (i == 1) begin
                chk("hi_din0", ap[0], 5'b00001);
                chk("hi_din1", ap[1], 5'b00010);
                repeat (3) @(negedge clk);
                chk("done_hold", done, 1'b1);
                chk("done_hold_sig", signature, 16'h0003);
            end
        end

        // zero seed falls back to 0xACE1 -> 0x59C3
        mode = 2'd0;
        run(16'h0000, 16'd2, 16'h0000, 1'b0);
        chk("zseed_din0", ap[0], 5'b00001);
        chk("zseed_din1", ap[1], 5'b00011);

        // foreign start mid-APPLY is ignored
        mode = 2'd1;
        run(16'h0001, 16'd3, 16'h0007, 1'b1);
        chk("poke_sig", signature, 16'h0007);
        chk("poke_pass", pass, 1'b1);
        chk("poke_busy_held", busy_low, 1'b0);
        chk("poke_din0", ap[0], 5'b00001);
        chk("poke_din2", ap[2], 5'b00100);

        // reset during APPLY
        @(negedge clk);
        seed = 16'h0001; pat_cnt = 16'd10; golden = 16'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_in_apply", dut_rst, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_dut_rst", dut_rst, 1'b1);
        chk("mid_busy", busy, 1'b0);
        chk("mid_sig", signature, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_busy", busy, 1'b0);
        chk("post_done", done, 1'b0);
        chk("post_pass", pass, 1'b0);
        chk("post_sig", signature, 16'h0);
        chk("post_dut_in", dut_in, '0);
        run(16'h0001, 16'd2, 16'h0003, 1'b0);
        chk("post_run_sig", signature, 16'h0003);
        chk("post_run_pass", pass, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/subckt_bist_ctrl.md
Name: subckt_bist_ctrl

Overview:
- Built-in self-test sequencer for one netlist subcircuit block: single-bit output, NIN data inputs, registered through DFFARX1 stages.
- Resets the target, drives it with an LFSR pattern stream, and compacts its output into a MISR signature, aligned to the target's flop latency.
- Compares the signature against a golden value and reports pass/fail.
- Sits beside each benchmark subcircuit as its test controller.

Parameters:
- NIN, 5, number of target data inputs driven from the LFSR low bits (1..16)
- LAT, 2, target input-to-output register latency in cycles (1..8)
- RST_CYC, 2, cycles dut_rst is held during target reset (>=1)
- CNT_W, 16, width of the pattern-count register

Ports:
- I1470_clk input 1: clock; all flops rising-edge.
- I1477_rst input 1: reset, asynchronous, active-high.
- start input 1: one-cycle request; accepted only in IDLE or DONE.
- seed input 16: LFSR seed, sampled on accepted start.
- pat_cnt input CNT_W: number of patterns, sampled on accepted start.
- golden input 16: expected signature, sampled on accepted start.
- dut_out input 1: target output.
- dut_in output NIN: target data inputs.
- dut_rst output 1: active-high reset to the target.
- busy output 1: high from the cycle after an accepted start until the cycle DONE is entered.
- done output 1: high while in DONE.
- pass output 1: valid while done; 1 iff signature equals golden.
- signature output 16: current MISR value.

Behaviour:
- Reset while I1477_rst=1: state IDLE, lfsr=0, misr=0, counters=0, vld_pipe=0, busy=done=pass=0, dut_in=0. dut_rst = I1477_rst OR (state==TRST), so the target is held in reset combinationally.
- FSM states: IDLE, TRST, APPLY, FLUSH, CMP, DONE.
- IDLE/DONE, start=1:
  - Latch seed, pat_cnt and golden.
  - lfsr <= (seed==0) ? 16'hACE1 : seed.
  - Clear misr and vld_pipe; rcnt <= RST_CYC-1; enter TRST.
  - DONE with start=0 holds all outputs.
- TRST: dut_rst=1, dut_in=0, nothing captured. When rcnt==0: go to APPLY if pat_cnt!=0, else FLUSH. Otherwise decrement rcnt.
- APPLY:
  - dut_in = lfsr[NIN-1:0].
  - Each cycle, lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}; pcnt increments.
  - vld_pipe shifts in 1.
  - After pat_cnt patterns have been applied, go to FLUSH with fcnt=LAT-1.
- FLUSH: dut_in=0; vld_pipe shifts in 0; lfsr frozen. When fcnt==0, go to CMP; otherwise decrement fcnt.
- Capture:
  - vld_pipe is a LAT-deep shift register. On any cycle where vld_pipe[LAT-1]=1, misr <= {misr[14:0], misr[15]^misr[13]^misr[12]^misr[10]} ^ {15'b0, dut_out}.
  - Exactly pat_cnt MISR updates occur per run. The first update uses dut_out from LAT cycles after the first APPLY cycle.
- CMP: pass_r <= (misr==golden_r); go to DONE. No MISR update occurs here (the pipe is empty by construction).
- start during TRST/APPLY/FLUSH/CMP: ignored, with no side effects.
- Async reset mid-run: immediate return to IDLE with all state cleared. No pass/done is reported for the aborted run.
- pat_cnt at its maximum value: the counter must not wrap early; pcnt compares for equality at CNT_W width.

Decomposition:
- Shared package bist_pkg holds:
  - the FSM state enum;
  - the polynomial tap constant 16'hB400 (bits 15,13,12,10);
  - the default seed 16'hACE1.
- One sub-module, bist_lfsr16: shared by the LFSR (mode=generate) and the MISR (mode=compact, with a 1-bit serial input), with load/enable/clear pins.

Test Plan:
1. Count zero: reset, then start with pat_cnt=0, golden=0 -> after TRST(2)+FLUSH(2)+CMP(1), done=1, pass=1, signature=0x0000, and no dut_in activity.
2. Output tied high: pat_cnt=2, seed=0x0001, dut_out tied 1 -> dut_in sequence 5'b00001, 5'b00010; signature=0x0003; with golden=0x0003 -> pass=1; a rerun with golden=0x0002 -> pass=0.
3. Zero seed: start with seed=0 -> first APPLY dut_in=5'b00001 (0xACE1 low bits); lfsr never locks at zero.
4. Latency alignment: a behavioural target that is dut_in[0] delayed LAT=2 cycles, pat_cnt=1, seed=0x0001 -> exactly one MISR update; signature=0x0001.
5. Ignored start: pulse start mid-APPLY with a different seed -> sequence and final signature identical to an undisturbed run; busy stays high.
6. Reset mid-run: assert I1477_rst during APPLY -> same-cycle dut_rst=1; after release: IDLE, busy=done=pass=0, signature=0; a fresh start completes normally.
